// File: rtl/ccm_pkg.sv
// Shared widths and types for the CCM line buffer.
// BUF_END is the first invalid address, held in pointer width so that range checks compare like with like.
package ccm_pkg;

    localparam int BIT_WIDTH = 8;
    localparam int BUF_WIDTH = 9;
    localparam int BUF_SIZE  = 257;

    typedef logic [BIT_WIDTH-1:0] data_t;
    typedef logic [BUF_WIDTH-1:0] ptr_t;

    localparam ptr_t BUF_END = ptr_t'(BUF_SIZE);

endpackage

// File: rtl/ccm_reg_cell.sv
// One storage word of the line buffer: asynchronous clear, loads d on a write strobe.
module ccm_reg_cell
    import ccm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en,
    input  data_t d,
    output data_t q
);

    // An X strobe is not taken as true, so unknown pointers leave the cell untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ccm_register_array.sv
// 257 x 8 register-file line buffer: unconditional write at wr_ptr and a registered read at rd_ptr.
// Reads return the pre-write contents when both pointers hit the same entry on one edge.
module ccm_register_array
    import ccm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  ptr_t rd_ptr,
    input  ptr_t wr_ptr,
    input  data_t data_in,
    output data_t data_out
);

    logic [BUF_SIZE-1:0] wr_strobe;
    data_t               mem [BUF_SIZE];

    // Only addresses 0..BUF_SIZE-1 have a decoder, so higher write addresses change nothing.
    for (genvar i = 0; i < BUF_SIZE; i++) begin : g_cell
        localparam ptr_t CELL_ADDR = ptr_t'(i);

        assign wr_strobe[i] = (wr_ptr == CELL_ADDR);

        ccm_reg_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .wr_en (wr_strobe[i]),
            .d     (data_in),
            .q     (mem[i])
        );
    end

    // Out-of-range or unknown read addresses fall to the zero branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_ptr < BUF_END) begin
            data_out <= mem[rd_ptr];
        end else begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_ccm_register_array.sv
// Directed bench for the CCM line buffer; inputs change 1 ns after a rising edge, outputs are sampled there too.
module tb_ccm_register_array;
    import ccm_pkg::*;

    logic  clk;
    logic  rst_n;
    ptr_t  rd_ptr;
    ptr_t  wr_ptr;
    data_t data_in;
    data_t data_out;

    int n_checks;
    int n_errors;

    ccm_register_array dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input data_t got, input data_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic drive(input ptr_t rd, input ptr_t wr, input data_t d);
        rd_ptr  = rd;
        wr_ptr  = wr;
        data_in = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(9'd0, 9'd300, 8'h00);

        // reset held across edges
        #2;
        check("reset_async", data_out, 8'h00);
        repeat (3) tick();
        check("reset_held", data_out, 8'h00);
        rst_n = 1'b1;
        tick();
        check("reset_release_rd0", data_out, 8'h00);

        // fill 0..255 with their index, 256 with 0xA5
        for (int i = 0; i < 256; i++) begin
            drive(9'd300, ptr_t'(i), data_t'(i));
            tick();
        end
        drive(9'd300, 9'd256, 8'hA5);
        tick();

        // readback sweep with one cycle latency
        for (int i = 0; i < 257; i++) begin
            drive(ptr_t'(i), 9'd300, 8'h00);
            tick();
            check($sformatf("fill_rd_%0d", i), data_out, (i < 256) ? data_t'(i) : 8'hA5);
        end

        // descending sweep: read i-1 while writing i, old fill value expected
        for (int i = 256; i >= 1; i--) begin
            drive(ptr_t'(i - 1), ptr_t'(i), data_t'(i));
            tick();
            check($sformatf("desc_rd_%0d", i - 1), data_out, data_t'(i - 1));
        end
        drive(9'd256, 9'd300, 8'h00);
        tick();
        check("desc_e256", data_out, 8'h00);
        drive(9'd255, 9'd300, 8'h00);
        tick();
        check("desc_e255", data_out, 8'hFF);
        drive(9'd1, 9'd300, 8'h00);
        tick();
        check("desc_e1", data_out, 8'h01);

        // same-address collision
        drive(9'd300, 9'd5, 8'h11);
        tick();
        drive(9'd5, 9'd5, 8'h22);
        tick();
        check("coll_old", data_out, 8'h11);
        drive(9'd5, 9'd300, 8'h00);
        tick();
        check("coll_new", data_out, 8'h22);

        // out-of-range write and read
        drive(9'd300, 9'd300, 8'hFF);
        tick();
        drive(9'd0, 9'd511, 8'hFF);
        tick();
        check("oor_e0", data_out, 8'h00);
        drive(9'd256, 9'd257, 8'hFF);
        tick();
        check("oor_e256", data_out, 8'h00);
        drive(9'd44, 9'd300, 8'h00);
        tick();
        check("oor_e44", data_out, 8'h2C);
        drive(9'd300, 9'd300, 8'h00);
        tick();
        check("oor_rd300", data_out, 8'h00);
        drive(9'd44, 9'd300, 8'h00);
        tick();
        check("pre_rst_e44", data_out, 8'h2C);
        drive(9'd511, 9'd300, 8'h00);
        tick();
        check("oor_rd511", data_out, 8'h00);

        // mid-operation reset, held over one edge with a write pending
        drive(9'd44, 9'd300, 8'h00);
        tick();
        check("pre_rst_e44b", data_out, 8'h2C);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", data_out, 8'h00);
        drive(9'd44, 9'd7, 8'h77);
        tick();
        check("midrst_held", data_out, 8'h00);
        drive(9'd300, 9'd300, 8'h00);
        rst_n = 1'b1;

        // every entry cleared, and the write under reset was blocked
        for (int i = 0; i < 257; i++) begin
            drive(ptr_t'(i), 9'd300, 8'h00);
            tick();
            check($sformatf("post_rst_rd_%0d", i), data_out, 8'h00);
        end

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ccm_register_array.md
Name: ccm_register_array

Overview:
- Single-clock register-file line buffer for the CCM datapath, 257 entries × 8 bits.
- Writes `data_in` to the entry at `wr_ptr` every clock.
- Presents the entry at `rd_ptr` on `data_out` one clock later.
- No enables and no handshake: the producer and consumer address the buffer directly with free-running pointers.

Parameters:
- BIT_WIDTH, 8, data word width in bits.
- BUF_WIDTH, 9, pointer width in bits.
- BUF_SIZE, 257, number of storage entries (valid addresses 0..BUF_SIZE-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_ptr  input  BUF_WIDTH  read address.
- wr_ptr  input  BUF_WIDTH  write address.
- data_in  input  BIT_WIDTH  write data.
- data_out  output  BIT_WIDTH  registered read data.

Behaviour:
- Reset: when rst_n is low, all BUF_SIZE entries and data_out clear to 0 immediately, with no clock required. Reset held low blocks all writes.
- Reset release: the first active edge is the first rising clk edge with rst_n high.
- Reset mid-operation: any in-flight read result is discarded and data_out returns to 0.
- Write: every rising edge with rst_n high, mem[wr_ptr] <= data_in.
  - There is no write enable.
  - A write is performed only if wr_ptr < BUF_SIZE.
  - Addresses BUF_SIZE..2^BUF_WIDTH-1 (257..511) are silently ignored; no entry changes.
- Read: every rising edge, data_out <= mem[rd_ptr].
  - Latency is 1 cycle from address to data.
  - data_out holds its value between edges.
  - If rd_ptr >= BUF_SIZE, data_out <= 0.
- Read/write collision: when rd_ptr == wr_ptr on the same edge, data_out gets the OLD contents (read-before-write). The new data is visible from the next edge onward.
- Unknown inputs: X/Z on the pointers must not corrupt other entries in simulation; treat them as out of range.
- Pointer order: there is no full/empty tracking and no wrap logic. The pointers are externally managed and may take any order.
- Timing: no combinational path from any input to data_out.

Decomposition:
- Shared package ccm_pkg holds BIT_WIDTH, BUF_WIDTH, BUF_SIZE and the typedefs:
  - data_t = logic [BIT_WIDTH-1:0]
  - ptr_t = logic [BUF_WIDTH-1:0]
- Top-level module contents:
  - the write-decode generate loop;
  - the read mux plus output register.
- Optional sub-module ccm_reg_cell is one BIT_WIDTH register with asynchronous clear and a write strobe, instantiated BUF_SIZE times.

Test Plan:
- Reset: hold rst_n=0, toggle clk -> data_out=0; after release with rd_ptr=0 and no writes -> data_out=0.
- Fill then readback:
  - For i=0..255 drive wr_ptr=i, data_in=i for one cycle each.
  - Then sweep rd_ptr=0..255 -> data_out=i exactly one cycle after rd_ptr=i.
  - Also read entry 256 after writing 0xA5 there -> data_out=0xA5.
- Descending sweep with collision:
  - For i=256 down to 1, drive rd_ptr=i-1, wr_ptr=i, data_in=i[7:0].
  - Required: data_out equals the previously written mem[i-1] (value i-1 from the fill), not the new data.
  - Check that entry 256 written with 256[7:0]=0x00 reads back 0x00.
- Same-address collision: mem[5]=0x11; write 0x22 with wr_ptr=rd_ptr=5 -> data_out=0x11 that cycle, 0x22 on the next cycle.
- Out-of-range: write 0xFF at wr_ptr=300 -> no entry changes (spot-check 0, 44, 256); rd_ptr=300 -> data_out=0.
- Mid-operation reset: pulse rst_n low between clock edges -> data_out=0 immediately, and every entry reads 0 afterwards.
